// File: rtl/converter_pkg.sv
// converter_pkg: shared types, character constants and classification helpers
// for the infix-to-postfix converter.
//   state_t      : conversion FSM states
//   CH_*         : ASCII codes of the characters the converter treats specially
//   is_operand   : single-character operand test (a-z, A-Z, 0-9)
//   is_operator  : arithmetic operator test (+ - * /)
//   prec         : operator precedence (2 for * /, 1 for + -, 0 for '(' and others)
package converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_MUL    = 8'h2A;
  localparam logic [7:0] CH_DIV    = 8'h2F;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  function automatic logic is_operand(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) ||
           ((c >= 8'h41) && (c <= 8'h5A)) ||
           ((c >= 8'h30) && (c <= 8'h39));
  endfunction

  function automatic logic is_operator(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_MUL) || (c == CH_DIV);
  endfunction

  function automatic logic [1:0] prec(input logic [7:0] c);
    if ((c == CH_MUL) || (c == CH_DIV)) begin
      return 2'd2;
    end else if ((c == CH_PLUS) || (c == CH_MINUS)) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/converter_stack.sv
// converter_stack: LIFO of SIZE entries x 8 bits holding pending operators.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, empties the stack
//   push  : write din on top (ignored when full)
//   pop   : remove the top entry (ignored when empty)
//   din   : data to push
//   top   : current top entry (0 when empty)
//   empty : no entries held
// push and pop are never asserted together by the converter.
module converter_stack
  import converter_pkg::*;
#(
  parameter int SIZE = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] top,
  output logic       empty
);

  localparam int PW = $clog2(SIZE + 1);

  logic [7:0]    mem [SIZE];
  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && (int'(cnt) < SIZE)) begin
      cnt <= cnt + 1'b1;
    end else if (pop && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: entries above cnt are never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < SIZE; k++) begin
      if (push && (int'(cnt) == k)) begin
        mem[k] <= din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (int'(cnt) == k + 1) begin
        top = mem[k];
      end
    end
  end

  assign empty = (cnt == '0);

endmodule

// File: rtl/converter.sv
// converter: streaming infix-to-postfix converter (shunting-yard).
// Reads the fixed expression EXPR (SIZE characters, leftmost in the MSBs) and
// emits the postfix form one character per OUT/SEND_STB/REC_ACK handshake,
// then raises FINISHED_ACK until RST.
//   CLK          : clock, rising edge
//   RST          : synchronous active-high reset, restarts from character 0
//   REC_ACK      : sink accepts OUT this cycle
//   OUT          : registered postfix character
//   SEND_STB     : OUT holds a valid character
//   FINISHED_ACK : conversion complete, every character accepted
// Optional build macro CONVERTER_PAREN_EN adds '(' / ')' grouping; without it
// parentheses are skipped like any other unrecognised character.
//
// state | meaning
// IDLE  | one cycle after reset before scanning starts
// SCAN  | one action per step on character idx (emit, pop, push or skip)
// FLUSH | pop and emit the remaining stack, one entry per step
// DONE  | FINISHED_ACK high, holds until RST
module converter
  import converter_pkg::*;
#(
  parameter int                SIZE = 9,
  parameter logic [8*SIZE-1:0] EXPR = "a+b*c-d/e"
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REC_ACK,
  output logic [7:0] OUT,
  output logic       SEND_STB,
  output logic       FINISHED_ACK
);

  localparam int            IW   = $clog2(SIZE + 1);
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    out_nxt;
  logic          stb_nxt;
  logic          push, pop;
  logic [7:0]    top;
  logic          empty;
  logic [7:0]    cur;
  logic          slot_free;
  logic          advance;
  logic [7:0]    chars [SIZE];

`ifdef CONVERTER_PAREN_EN
  localparam int PW = $clog2(SIZE + 1);
  logic [PW-1:0] paren_cnt, paren_cnt_nxt;
`endif

  for (genvar g = 0; g < SIZE; g++) begin : g_chars
    assign chars[g] = EXPR[8*(SIZE-1-g) +: 8];
  end

  always_comb begin
    cur = CH_SPACE;
    for (int k = 0; k < SIZE; k++) begin
      if (int'(idx) == k) begin
        cur = chars[k];
      end
    end
  end

  // The output register can take a new character if it is empty or its
  // current character is being accepted on this same edge.
  assign slot_free = !SEND_STB || REC_ACK;

  converter_stack #(.SIZE(SIZE)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (cur),
    .top   (top),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      OUT      <= 8'h00;
      SEND_STB <= 1'b0;
`ifdef CONVERTER_PAREN_EN
      paren_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      OUT      <= out_nxt;
      SEND_STB <= stb_nxt;
`ifdef CONVERTER_PAREN_EN
      paren_cnt <= paren_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    out_nxt   = OUT;
    stb_nxt   = SEND_STB && !REC_ACK;
    push      = 1'b0;
    pop       = 1'b0;
    advance   = 1'b0;
`ifdef CONVERTER_PAREN_EN
    paren_cnt_nxt = paren_cnt;
`endif

    case (state)
      IDLE: begin
        state_nxt = SCAN;
      end

      SCAN: begin
        if (is_operand(cur)) begin
          if (slot_free) begin
            out_nxt = cur;
            stb_nxt = 1'b1;
            advance = 1'b1;
          end
        end else if (is_operator(cur)) begin
          // Left-associative: equal precedence on top is popped first.
          if (!empty && is_operator(top) && (prec(top) >= prec(cur))) begin
            if (slot_free) begin
              pop     = 1'b1;
              out_nxt = top;
              stb_nxt = 1'b1;
            end
          end else begin
            push    = 1'b1;
            advance = 1'b1;
          end
`ifdef CONVERTER_PAREN_EN
        end else if (cur == CH_LPAREN) begin
          push          = 1'b1;
          advance       = 1'b1;
          paren_cnt_nxt = paren_cnt + 1'b1;
        end else if (cur == CH_RPAREN) begin
          // paren_cnt tells whether a matching '(' exists somewhere below.
          if (paren_cnt == '0) begin
            advance = 1'b1;
          end else if (top == CH_LPAREN) begin
            pop           = 1'b1;
            advance       = 1'b1;
            paren_cnt_nxt = paren_cnt - 1'b1;
          end else if (slot_free) begin
            pop     = 1'b1;
            out_nxt = top;
            stb_nxt = 1'b1;
          end
`endif
        end else begin
          advance = 1'b1;
        end

        if (advance) begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST) begin
            state_nxt = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (empty) begin
          // Finish only once the last character has left the output slot.
          if (slot_free) begin
            state_nxt = DONE;
          end
`ifdef CONVERTER_PAREN_EN
        end else if (top == CH_LPAREN) begin
          pop = 1'b1;
`endif
        end else if (slot_free) begin
          pop     = 1'b1;
          out_nxt = top;
          stb_nxt = 1'b1;
        end
      end

      DONE: begin
        state_nxt = DONE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign FINISHED_ACK = (state == DONE);

endmodule

// File: tb/tb_converter.sv
module tb_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rec_def = 1'b1;
  logic rec_aux = 1'b1;

  logic [7:0] out_def, out_sub, out_par, out_sp;
  logic       stb_def, stb_sub, stb_par, stb_sp;
  logic       fin_def, fin_sub, fin_par, fin_sp;

  logic [7:0] q_def [$];
  logic [7:0] q_sub [$];
  logic [7:0] q_par [$];
  logic [7:0] q_sp  [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  converter u_def (
    .CLK(clk), .RST(rst), .REC_ACK(rec_def),
    .OUT(out_def), .SEND_STB(stb_def), .FINISHED_ACK(fin_def)
  );

  converter #(.SIZE(5), .EXPR("a-b-c")) u_sub (
    .CLK(clk), .RST(rst), .REC_ACK(rec_aux),
    .OUT(out_sub), .SEND_STB(stb_sub), .FINISHED_ACK(fin_sub)
  );

  converter #(.SIZE(7), .EXPR("(a+b)*c")) u_par (
    .CLK(clk), .RST(rst), .REC_ACK(rec_aux),
    .OUT(out_par), .SEND_STB(stb_par), .FINISHED_ACK(fin_par)
  );

  converter #(.SIZE(5), .EXPR("a + b")) u_sp (
    .CLK(clk), .RST(rst), .REC_ACK(rec_aux),
    .OUT(out_sp), .SEND_STB(stb_sp), .FINISHED_ACK(fin_sp)
  );

  // Inputs only change at posedge+2, so a strobe/ack pair seen at the
  // negedge is exactly the pair the next rising edge will transfer.
  always @(negedge clk) begin
    if (stb_def && rec_def) q_def.push_back(out_def);
    if (stb_sub && rec_aux) q_sub.push_back(out_sub);
    if (stb_par && rec_aux) q_par.push_back(out_par);
    if (stb_sp  && rec_aux) q_sp.push_back(out_sp);
  end

  function automatic string q2s(input logic [7:0] q [$]);
    string s = "";
    foreach (q[k]) s = $sformatf("%s%c", s, q[k]);
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rec_def = 1'b1;
    rec_aux = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_def !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", out_def); end
    total++; if (stb_def !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", stb_def); end
    total++; if (fin_def !== 1'b0) begin bad++; $display("FAIL reset_fin got=%b want=0", fin_def); end
    total++; if ({stb_sub, stb_par, stb_sp, fin_sub, fin_par, fin_sp} !== 6'b0)
      begin bad++; $display("FAIL reset_aux got=%b want=000000", {stb_sub, stb_par, stb_sp, fin_sub, fin_par, fin_sp}); end
  endtask

  task automatic test_default();
    int cyc;
    @(posedge clk); #2;
    q_def.delete(); q_sub.delete(); q_par.delete(); q_sp.delete();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (stb_def !== 1'b0) begin bad++; $display("FAIL idle_stb got=%b want=0", stb_def); end
    @(posedge clk);
    @(negedge clk);
    total++; if ({stb_def, out_def} !== {1'b1, 8'h61})
      begin bad++; $display("FAIL first_emit got=%b/%h want=1/61", stb_def, out_def); end
    cyc = 2;
    for (int c = 0; c < 100; c++) begin
      if (fin_def) break;
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    total++; if (fin_def !== 1'b1) begin bad++; $display("FAIL default_timeout fin=%b want=1", fin_def); end
    total++; if (cyc != 15) begin bad++; $display("FAIL default_latency got=%0d want=15", cyc); end
    total++; if (q2s(q_def) != "abc*+de/-") begin bad++; $display("FAIL default_seq got=%s want=abc*+de/-", q2s(q_def)); end
    total++; if (q_def.size() != 9) begin bad++; $display("FAIL default_count got=%0d want=9", q_def.size()); end
    total++; if (stb_def !== 1'b0) begin bad++; $display("FAIL done_stb got=%b want=0", stb_def); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if ({fin_def, stb_def} !== 2'b10 || q_def.size() != 9)
      begin bad++; $display("FAIL done_hold got=%b%b/%0d want=10/9", fin_def, stb_def, q_def.size()); end
  endtask

  task automatic test_assoc();
    for (int c = 0; c < 50 && !fin_sub; c++) @(negedge clk);
    total++; if (fin_sub !== 1'b1) begin bad++; $display("FAIL assoc_timeout fin=%b want=1", fin_sub); end
    total++; if (q2s(q_sub) != "ab-c-") begin bad++; $display("FAIL assoc_seq got=%s want=ab-c-", q2s(q_sub)); end
  endtask

  task automatic test_paren();
    string exp;
`ifdef CONVERTER_PAREN_EN
    exp = "ab+c*";
`else
    exp = "abc*+";
`endif
    for (int c = 0; c < 50 && !fin_par; c++) @(negedge clk);
    total++; if (fin_par !== 1'b1) begin bad++; $display("FAIL paren_timeout fin=%b want=1", fin_par); end
    total++; if (q2s(q_par) != exp) begin bad++; $display("FAIL paren_seq got=%s want=%s", q2s(q_par), exp); end
  endtask

  task automatic test_spaces();
    for (int c = 0; c < 50 && !fin_sp; c++) @(negedge clk);
    total++; if (fin_sp !== 1'b1) begin bad++; $display("FAIL spaces_timeout fin=%b want=1", fin_sp); end
    total++; if (q2s(q_sp) != "ab+") begin bad++; $display("FAIL spaces_seq got=%s want=ab+", q2s(q_sp)); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    q_def.delete();
    rst = 1'b0;
    rec_def = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({stb_def, out_def} !== {1'b1, 8'h61})
        begin bad++; $display("FAIL stall_hold_%0d got=%b/%h want=1/61", k, stb_def, out_def); end
      @(posedge clk); #2;
    end
    rec_def = 1'b1;
    for (int c = 0; c < 100 && !fin_def; c++) @(negedge clk);
    total++; if (fin_def !== 1'b1) begin bad++; $display("FAIL stall_timeout fin=%b want=1", fin_def); end
    total++; if (q2s(q_def) != "abc*+de/-") begin bad++; $display("FAIL stall_seq got=%s want=abc*+de/-", q2s(q_def)); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    q_def.delete();
    rst = 1'b0;
    rec_def = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (q_def.size() >= 4) break;
    end
    rst = 1'b1;
    rec_def = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if ({out_def, stb_def, fin_def} !== 10'h000)
      begin bad++; $display("FAIL midrst_regs got=%h/%b/%b want=00/0/0", out_def, stb_def, fin_def); end
    total++; if (q2s(q_def) != "abc*") begin bad++; $display("FAIL midrst_prefix got=%s want=abc*", q2s(q_def)); end
    @(posedge clk); #2;
    q_def.delete();
    rst = 1'b0;
    rec_def = 1'b1;
    for (int c = 0; c < 100 && !fin_def; c++) @(negedge clk);
    total++; if (fin_def !== 1'b1) begin bad++; $display("FAIL midrst_timeout fin=%b want=1", fin_def); end
    total++; if (q2s(q_def) != "abc*+de/-") begin bad++; $display("FAIL midrst_seq got=%s want=abc*+de/-", q2s(q_def)); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_assoc();
    test_paren();
    test_spaces();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
